// File: rtl/renode_pkg.sv
// Shared AHB-Lite encodings and helpers for the Renode co-simulation bridges.
package renode_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } ahb_htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } ahb_hsize_e;

  localparam int unsigned AHB_MAX_STRB = 8;

  // Lanes [addr_lsbs, addr_lsbs + 2**size) set; callers truncate to their bus width.
  function automatic logic [AHB_MAX_STRB-1:0] ahb_byte_strobe(input ahb_hsize_e size,
                                                             input logic [2:0] addr_lsbs);
    logic [AHB_MAX_STRB-1:0] strb;
    int unsigned nbytes;
    int unsigned lo;
    strb   = '0;
    nbytes = 32'd1 << size;
    lo     = 32'(addr_lsbs);
    for (int unsigned i = 0; i < AHB_MAX_STRB; i++) begin
      strb[i] = (i >= lo) && (i < lo + nbytes);
    end
    return strb;
  endfunction

endpackage

// File: rtl/renode_ahb_subordinate.sv
// AHB-Lite subordinate forwarding each beat to Renode over a valid/ready request
// channel and a single-pulse response channel; one beat outstanding at a time.
module renode_ahb_subordinate
  import renode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [3:0]              HBURST,
  input  logic                    HREADY,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rsp_error
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  ahb_hsize_e            size_q;
  logic [15:0]           tmo_cnt;
  logic                  can_accept;
  logic                  accept;
  logic                  beat_ok;
  logic                  misaligned;
  logic                  timeout;
  logic [7:0]            size_mask;
  logic [2:0]            lane_lsbs;
  logic                  hburst_unused;

  // Each beat is handled on its own, so the burst type carries no information here.
  assign hburst_unused = ^HBURST;

  assign can_accept = (state == S_IDLE) || (state == S_ERR2);
  assign accept     = HSEL && HREADY &&
                      (ahb_htrans_e'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign size_mask  = 8'((9'd1 << HSIZE) - 9'd1);
  assign misaligned = |(HADDR[2:0] & size_mask[2:0]);
  assign beat_ok    = (32'(HSIZE) <= MAX_SIZE) && !misaligned;
  assign timeout    = (TIMEOUT_CYCLES != 0) &&
                      (({1'b0, tmo_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (accept) state_nxt = beat_ok ? S_REQ : S_ERR1;
        else        state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (req_ready) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid)    state_nxt = rsp_error ? S_ERR1 : S_IDLE;
        else if (timeout) state_nxt = S_ERR1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
      HRESP     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else if (can_accept && accept) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      size_q  <= ahb_hsize_e'(HSIZE);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT_RSP) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HRDATA <= '0;
    end else if ((state == S_WAIT_RSP) && rsp_valid && !rsp_error && !write_q) begin
      HRDATA <= rsp_rdata;
    end
  end

  assign req_valid = (state == S_REQ);
  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_wdata = HWDATA;
  assign lane_lsbs = addr_q[2:0] & 3'(STRB_WIDTH - 1);
  assign req_strb  = STRB_WIDTH'(ahb_byte_strobe(size_q, lane_lsbs));

endmodule

// File: tb/tb_renode_ahb_subordinate.sv
// Scoreboard bench: AHB manager driver, Renode-side responder, and a decoupled monitor.
module tb_renode_ahb_subordinate;
  import renode_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  renode_ahb_subordinate #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADYOUT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
  } bus_exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    int unsigned ready_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    logic        err;
  } rsp_cfg_t;

  typedef struct {
    logic        b2b;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int unsigned rdy;
    int          rsp;
    logic [31:0] rdata;
    logic        rerr;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic        exp_err;
    int unsigned exp_lat;
  } vec_t;

  bus_exp_t    busq[$];
  req_exp_t    reqq[$];
  rsp_cfg_t    cfgq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hrdata = '0;
  logic        renode_busy;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic b2b, input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input int unsigned rdy, input int rsp, input logic [31:0] rdata,
                              input logic rerr, input logic exp_req, input logic [3:0] exp_strb,
                              input logic exp_err, input int unsigned exp_lat);
    vec_t v;
    v.b2b = b2b; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.rerr = rerr;
    v.exp_req = exp_req; v.exp_strb = exp_strb; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
  initial begin : monitor
    logic        dphase;
    int unsigned lat;
    logic        prev_ready;
    logic        prev_resp;
    bus_exp_t    be;
    req_exp_t    re;
    dphase = 1'b0; lat = 0; prev_ready = 1'b1; prev_resp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dphase = 1'b0;
        lat    = 0;
      end else begin
        if (dphase) begin
          lat++;
          if (HREADYOUT) begin
            checks++;
            if (busq.size() == 0) begin
              errors++;
              $display("FAIL bus_unexpected: got completion HRESP=%0d, required none", HRESP);
            end else begin
              be = busq.pop_front();
              check("HRESP", 32'(HRESP), 32'(be.err));
              check("HRDATA", HRDATA, be.rdata);
              if (be.err) check("err_first_cycle", 32'({prev_ready, prev_resp}), 32'h1);
              if (be.lat != 0) check("latency", lat, be.lat);
            end
            dphase = 1'b0;
            lat    = 0;
          end
        end
        if (req_valid && req_ready) begin
          checks++;
          if (reqq.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected: got request addr 0x%h, required none", req_addr);
          end else begin
            re = reqq.pop_front();
            check("req_write", 32'(req_write), 32'(re.write));
            check("req_addr", req_addr, re.addr);
            check("req_strb", 32'(req_strb), 32'(re.strb));
            if (re.write) check("req_wdata", req_wdata, re.wdata);
          end
        end
        if (HSEL && HREADYOUT && HTRANS[1]) dphase = 1'b1;
      end
      prev_ready = HREADYOUT;
      prev_resp  = HRESP;
    end
  end

  // Renode side: accepts requests after a per-beat delay and answers with one pulse.
  initial begin : renode_side
    rsp_cfg_t cfg;
    int       phase;
    int       cnt;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_error = 1'b0; rsp_rdata = '0;
    renode_busy = 1'b0; phase = 0; cnt = 0;
    cfg.ready_dly = 0; cfg.rsp_dly = 1; cfg.rdata = '0; cfg.err = 1'b0;
    forever begin
      @(posedge HCLK); #1;
      rsp_valid = 1'b0;
      rsp_error = 1'b0;
      if (HRESET) begin
        req_ready = 1'b0; phase = 0; renode_busy = 1'b0;
      end else begin
        case (phase)
          0: if (req_valid) begin
               renode_busy = 1'b1;
               if (cfgq.size() != 0) cfg = cfgq.pop_front();
               else begin cfg.ready_dly = 0; cfg.rsp_dly = 1; cfg.rdata = '0; cfg.err = 1'b0; end
               cnt = int'(cfg.ready_dly);
               if (cnt == 0) begin req_ready = 1'b1; phase = 2; end
               else phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin req_ready = 1'b1; phase = 2; end
             end
          2: begin
               req_ready = 1'b0;
               if (cfg.rsp_dly < 1) begin
                 phase = 0; renode_busy = 1'b0;
               end else if (cfg.rsp_dly == 1) begin
                 rsp_valid = 1'b1; rsp_rdata = cfg.rdata; rsp_error = cfg.err;
                 phase = 0; renode_busy = 1'b0;
               end else begin
                 cnt = cfg.rsp_dly; phase = 3;
               end
             end
          default: begin
               cnt--;
               if (cnt == 1) begin
                 rsp_valid = 1'b1; rsp_rdata = cfg.rdata; rsp_error = cfg.err;
                 phase = 0; renode_busy = 1'b0;
               end
             end
        endcase
      end
    end
  end

  task automatic beat(input vec_t v);
    bus_exp_t    be;
    req_exp_t    re;
    rsp_cfg_t    c;
    int unsigned guard;
    if (v.exp_req) begin
      c.ready_dly = v.rdy; c.rsp_dly = v.rsp; c.rdata = v.rdata; c.err = v.rerr;
      cfgq.push_back(c);
      re.write = v.wr; re.addr = v.addr; re.strb = v.exp_strb; re.wdata = v.wdata;
      reqq.push_back(re);
    end
    if (!v.exp_err && !v.wr) model_hrdata = v.rdata;
    be.err = v.exp_err; be.rdata = model_hrdata; be.lat = v.exp_lat;
    busq.push_back(be);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size;
    guard = 0;
    while (!HREADYOUT && guard < 100) begin @(posedge HCLK); #1; guard++; end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL addr_phase_timeout: got HREADYOUT=0 for %0d cycles, required 1", guard);
    end
    @(posedge HCLK); #1;
    HWDATA = v.wdata; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  task automatic idle_wait();
    int unsigned guard;
    guard = 0;
    while ((busq.size() != 0 || reqq.size() != 0 || renode_busy || rsp_valid || !HREADYOUT)
           && guard < 200) begin
      @(posedge HCLK); #1; guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending completions, required 0", busq.size());
    end
    @(posedge HCLK); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[12];

  initial begin : stimulus
    vecs[0]  = mk(0, 0, 32'h100, 3'd2, 32'h0,        0, 1, 32'hDEADBEEF, 0, 1, 4'hF, 0, 3);
    vecs[1]  = mk(0, 1, 32'h103, 3'd0, 32'hAA000000, 0, 1, 32'h0,        0, 1, 4'h8, 0, 3);
    vecs[2]  = mk(0, 0, 32'h104, 3'd2, 32'h0,        0, 1, 32'h55555555, 1, 1, 4'hF, 1, 4);
    vecs[3]  = mk(0, 0, 32'h108, 3'd3, 32'h0,        0, 1, 32'h0,        0, 0, 4'h0, 1, 2);
    vecs[4]  = mk(0, 1, 32'h101, 3'd1, 32'h12340000, 0, 1, 32'h0,        0, 0, 4'h0, 1, 2);
    vecs[5]  = mk(0, 0, 32'h10C, 3'd2, 32'h0,        0, 6, 32'h12345678, 0, 1, 4'hF, 1, 7);
    vecs[6]  = mk(0, 1, 32'h110, 3'd2, 32'h11223344, 3, 1, 32'h0,        0, 1, 4'hF, 0, 6);
    vecs[7]  = mk(1, 0, 32'h114, 3'd2, 32'h0,        3, 1, 32'hCAFEF00D, 0, 1, 4'hF, 0, 6);
    vecs[8]  = mk(1, 1, 32'h116, 3'd1, 32'hBEEF0000, 0, 2, 32'h0,        0, 1, 4'hC, 0, 4);
    vecs[9]  = mk(0, 1, 32'h121, 3'd1, 32'h0,        0, 1, 32'h0,        0, 0, 4'h0, 1, 2);
    vecs[10] = mk(1, 0, 32'h124, 3'd2, 32'h0,        0, 1, 32'h0F0F0F0F, 0, 1, 4'hF, 0, 3);
    vecs[11] = mk(0, 1, 32'h128, 3'd2, 32'hA5A5A5A5, 1, 1, 32'h0,        0, 1, 4'hF, 0, 4);

    HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 4'd0; HWDATA = '0;
    HRESET = 1'b1;
    #1;
    check("reset_HREADYOUT", 32'(HREADYOUT), 32'h1);
    check("reset_HRESP", 32'(HRESP), 32'h0);
    check("reset_HRDATA", HRDATA, 32'h0);
    check("reset_req_valid", 32'(req_valid), 32'h0);
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(posedge HCLK); #1;

    // BUSY with HSEL high is a zero-wait OKAY that issues no request.
    HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h180;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    check("busy_HREADYOUT", 32'(HREADYOUT), 32'h1);
    check("busy_HRESP", 32'(HRESP), 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (!vecs[i].b2b) idle_wait();
      beat(vecs[i]);
    end
    idle_wait();

    // Asynchronous reset while a read waits for its response.
    begin
      rsp_cfg_t c;
      req_exp_t re;
      c.ready_dly = 0; c.rsp_dly = -1; c.rdata = 32'h77777777; c.err = 1'b0;
      cfgq.push_back(c);
      re.write = 1'b0; re.addr = 32'h200; re.strb = 4'hF; re.wdata = '0;
      reqq.push_back(re);
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h200; HWRITE = 1'b0; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      @(posedge HCLK); #1;
      @(posedge HCLK); #3;
      check("wait_rsp_HREADYOUT", 32'(HREADYOUT), 32'h0);
      HRESET = 1'b1;
      #1;
      check("midreset_HREADYOUT", 32'(HREADYOUT), 32'h1);
      check("midreset_HRESP", 32'(HRESP), 32'h0);
      check("midreset_HRDATA", HRDATA, 32'h0);
      check("midreset_req_valid", 32'(req_valid), 32'h0);
      model_hrdata = '0;
      repeat (2) @(posedge HCLK);
      #1 HRESET = 1'b0;
      check("midreset_reqq_drained", 32'(reqq.size()), 32'h0);
    end

    idle_wait();
    beat(mk(0, 0, 32'h0, 3'd2, 32'h0, 0, 3, 32'h0BADF00D, 0, 1, 4'hF, 0, 5));
    idle_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
